// File: rtl/user_input_event_arbiter.sv
// user_input_event_arbiter
//   Collects one-cycle event pulses from the rotary decoder, the rotary
//   push-button and the debounced push-buttons. A round-robin arbiter moves
//   them into an event FIFO, which the MMIO block drains through valid/ready.
//   The block also keeps a saturating signed rotary position and a saturating
//   count of dropped events.
//
//   Sources: 0 = rotary turn, 1 = rotary push, 2.. = button_pulse[i-2]
//   Event byte: [7:5] type (001 right, 010 left, 011 push, 100 button),
//               [4:0] index (button number, else 0)
//
//   Optional build macro EVENT_TIMESTAMP_EN: adds a free-running 16-bit cycle
//   counter. Its value is captured when a pulse is accepted, and
//   event_data[23:8] carries it.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   rotary_event/_left   detent pulse and its direction (1 = left)
//   rotary_push          encoder shaft press pulse
//   button_pulse         one pulse line per button
//   clear                synchronous clear of FIFO/pending/position/drops
//   event_valid/_data    FIFO head (first-word-fall-through)
//   event_ready          consumer pops the head
//   fifo_count           FIFO occupancy
//   position             signed rotary position, saturating
//   drop_count           events lost to pending collisions, saturates at 255
module user_input_event_arbiter #(
  parameter int NUM_BUTTONS = 4,
  parameter int FIFO_DEPTH  = 8,
`ifdef EVENT_TIMESTAMP_EN
  localparam int DW = 24,
`else
  localparam int DW = 8,
`endif
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rotary_event,
  input  logic                   rotary_left,
  input  logic                   rotary_push,
  input  logic [NUM_BUTTONS-1:0] button_pulse,
  input  logic                   clear,
  output logic                   event_valid,
  output logic [DW-1:0]          event_data,
  input  logic                   event_ready,
  output logic [AW:0]            fifo_count,
  output logic [15:0]            position,
  output logic [7:0]             drop_count
);
  localparam int NSRC = NUM_BUTTONS + 2;
  localparam int SW   = $clog2(NSRC);

  logic [NSRC-1:0] pend_q, pend_d, pulse, drop, gnt_vec;
  logic            dir_q, dir_d;
  logic [SW-1:0]   ptr_q, ptr_d, gnt_idx;
  logic            gnt_vld, push, pop, full;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [15:0]     pos_q, pos_d;
  logic [7:0]      drop_q, drop_d;
  logic [8:0]      drop_sum;
  logic [7:0]      gnt_code;
  logic [DW-1:0]   gnt_data;
  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  int              j;

  assign pulse = {button_pulse, rotary_push, rotary_event};

  // ptr_q is the source the search starts at. It is 0 out of reset and
  // granted+1 after each grant, so the last granted source gets lowest priority.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NSRC) j = j - NSRC;
      if (pend_q[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(j);
      end
    end
  end

  assign full        = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign event_valid = (cnt_q != '0);
  assign pop         = event_valid && event_ready;
  // A full FIFO still accepts a grant when the head leaves in the same cycle.
  assign push        = gnt_vld && (!full || pop);
  assign gnt_vec     = push ? (NSRC'(1) << gnt_idx) : '0;

  always_comb begin
    gnt_code = {3'b100, 5'(gnt_idx - SW'(2))};
    if (gnt_idx == SW'(0))      gnt_code = {(dir_q ? 3'b010 : 3'b001), 5'd0};
    else if (gnt_idx == SW'(1)) gnt_code = {3'b011, 5'd0};
  end

`ifdef EVENT_TIMESTAMP_EN
  logic [15:0]            ts_cnt_q;
  logic [NSRC-1:0][15:0]  ts_q;
  assign gnt_data = {ts_q[gnt_idx], gnt_code};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
      for (int i = 0; i < NSRC; i++)
        if (pulse[i] && !(pend_q[i] && !gnt_vec[i])) ts_q[i] <= ts_cnt_q;
    end
  end
`else
  assign gnt_data = gnt_code;
`endif

  always_comb begin
    pend_d = pend_q;
    dir_d  = dir_q;
    drop   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pulse[i] && pend_q[i] && !gnt_vec[i]) begin
        drop[i] = 1'b1;           // collision: keep the original event
      end else if (pulse[i]) begin
        pend_d[i] = 1'b1;         // new or refilled-on-grant slot
        if (i == 0) dir_d = rotary_left;
      end else if (gnt_vec[i]) begin
        pend_d[i] = 1'b0;
      end
    end

    ptr_d = ptr_q;
    if (push) ptr_d = (gnt_idx == SW'(NSRC - 1)) ? '0 : gnt_idx + SW'(1);

    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    drop_sum = 9'(drop_q) + 9'($countones(drop));
    drop_d   = (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];

    pos_d = pos_q;
    if (rotary_event) begin
      if (rotary_left && pos_q != 16'h8000)       pos_d = pos_q - 16'd1;
      else if (!rotary_left && pos_q != 16'h7fff) pos_d = pos_q + 16'd1;
    end

    if (clear) begin
      pend_d = '0;
      dir_d  = 1'b0;
      ptr_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      drop_d = '0;
      pos_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      dir_q  <= 1'b0;
      ptr_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      pos_q  <= '0;
    end else begin
      pend_q <= pend_d;
      dir_q  <= dir_d;
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      pos_q  <= pos_d;
    end
  end

  // The storage array needs no reset because the output is masked while the FIFO is empty.
  always_ff @(posedge clk)
    if (push && !clear) mem_q[wr_q] <= gnt_data;

  assign event_data = event_valid ? mem_q[rd_q] : '0;
  assign fifo_count = cnt_q;
  assign position   = pos_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_user_input_event_arbiter.sv
module tb_user_input_event_arbiter;
  localparam int NB = 4;

  logic          clk = 1'b0, clk_en = 1'b1;
  logic          rst;
  logic          rotary_event, rotary_left, rotary_push, clear, event_ready;
  logic [NB-1:0] button_pulse;
  logic          event_valid;
  logic [7:0]    event_data;
  logic [3:0]    fifo_count;
  logic [15:0]   position;
  logic [7:0]    drop_count;

  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q [$];

  user_input_event_arbiter #(.NUM_BUTTONS(NB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .rotary_event(rotary_event), .rotary_left(rotary_left),
    .rotary_push(rotary_push), .button_pulse(button_pulse), .clear(clear),
    .event_valid(event_valid), .event_data(event_data), .event_ready(event_ready),
    .fifo_count(fifo_count), .position(position), .drop_count(drop_count)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: every accepted head is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && event_valid && event_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", {24'b0, event_data}, 32'hffff_ffff);
      else chk("pop_data", {24'b0, event_data}, {24'b0, exp_q.pop_front()});
    end
  end

  typedef struct {
    bit          rot, left, push;
    logic [3:0]  btn;
    logic [7:0]  exp_data;
    logic [15:0] exp_pos;
  } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0] = '{1, 0, 0, 4'b0000, 8'h20, 16'h0001};
    vecs[1] = '{1, 1, 0, 4'b0000, 8'h40, 16'hffff};
    vecs[2] = '{0, 0, 1, 4'b0000, 8'h60, 16'h0000};
    vecs[3] = '{0, 0, 0, 4'b0001, 8'h80, 16'h0000};
    vecs[4] = '{0, 0, 0, 4'b1000, 8'h83, 16'h0000};

    rst = 1'b1; rotary_event = 0; rotary_left = 0; rotary_push = 0;
    button_pulse = '0; clear = 0; event_ready = 0;
    #12;
    chk("rst_valid", {31'b0, event_valid}, 0);
    chk("rst_data", {24'b0, event_data}, 0);
    chk("rst_count", {28'b0, fifo_count}, 0);
    chk("rst_pos", {16'b0, position}, 0);
    chk("rst_drop", {24'b0, drop_count}, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Single-source latency and encoding
    foreach (vecs[v]) begin
      rotary_event = vecs[v].rot; rotary_left = vecs[v].left;
      rotary_push = vecs[v].push; button_pulse = vecs[v].btn;
      exp_q.push_back(vecs[v].exp_data);
      tick();
      rotary_event = 0; rotary_left = 0; rotary_push = 0; button_pulse = '0;
      chk("lat_edge1_valid", {31'b0, event_valid}, 0);
      tick();
      chk("lat_edge2_valid", {31'b0, event_valid}, 1);
      chk("one_count", {28'b0, fifo_count}, 1);
      chk("vec_pos", {16'b0, position}, {16'b0, vecs[v].exp_pos});
      event_ready = 1'b1;
      tick();
      event_ready = 1'b0;
      chk("drained_valid", {31'b0, event_valid}, 0);
      chk("drained_count", {28'b0, fifo_count}, 0);
      do_clear();
    end

    // Three simultaneous sources, consumer always ready
    rst = 1'b1; #2; rst = 1'b0;
    event_ready = 1'b1;
    rotary_event = 1; rotary_push = 1; button_pulse = 4'b0100;
    exp_q.push_back(8'h20); exp_q.push_back(8'h60); exp_q.push_back(8'h82);
    tick();
    rotary_event = 0; rotary_push = 0; button_pulse = '0;
    repeat (4) tick();
    chk("rr_all_popped", exp_q.size(), 0);
    chk("rr_valid", {31'b0, event_valid}, 0);
    chk("rr_drop", {24'b0, drop_count}, 0);
    event_ready = 1'b0;
    do_clear();

    // Fill the FIFO: 8 stored, 9th pends, 10th drops
    for (int p = 0; p < 10; p++) begin
      button_pulse = 4'b0001;
      if (p < 9) exp_q.push_back(8'h80);
      tick();
      button_pulse = '0;
      tick();
    end
    chk("full_count", {28'b0, fifo_count}, 8);
    chk("full_drop", {24'b0, drop_count}, 1);
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    chk("pop_admits_pending", {28'b0, fifo_count}, 8);
    event_ready = 1'b1;
    repeat (8) tick();
    event_ready = 1'b0;
    chk("drain_count", {28'b0, fifo_count}, 0);
    chk("drain_valid", {31'b0, event_valid}, 0);
    chk("drain_sb_empty", exp_q.size(), 0);
    do_clear();

    // Position and drop-count saturation
    rotary_event = 1; rotary_left = 1;
    repeat (40000) tick();
    rotary_event = 0; rotary_left = 0;
    chk("pos_sat_low", {16'b0, position}, 32'h8000);
    chk("drop_sat", {24'b0, drop_count}, 32'hff);
    rotary_event = 1;
    tick();
    rotary_event = 0;
    chk("pos_after_right", {16'b0, position}, 32'h8001);
    do_clear();

    // Clear with 3 entries, pending sources and a colliding pulse
    button_pulse = 4'b0111;
    tick();
    button_pulse = '0;
    repeat (3) tick();
    chk("pre_clear_count", {28'b0, fifo_count}, 3);
    button_pulse = 4'b1000; rotary_event = 1;
    tick();
    button_pulse = '0; rotary_event = 0;
    chk("pre_clear_pos", {16'b0, position}, 1);
    clear = 1'b1; button_pulse = 4'b0001;
    tick();
    clear = 1'b0; button_pulse = '0;
    chk("clr_count", {28'b0, fifo_count}, 0);
    chk("clr_valid", {31'b0, event_valid}, 0);
    chk("clr_pos", {16'b0, position}, 0);
    chk("clr_drop", {24'b0, drop_count}, 0);
    repeat (3) tick();
    chk("clr_pulse_ignored", {28'b0, fifo_count}, 0);

    // Asynchronous reset with the clock stopped
    button_pulse = 4'b0010; rotary_event = 1;
    tick();
    button_pulse = '0; rotary_event = 0;
    tick();
    chk("pre_rst_valid", {31'b0, event_valid}, 1);
    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, event_valid}, 0);
    chk("arst_data", {24'b0, event_data}, 0);
    chk("arst_count", {28'b0, fifo_count}, 0);
    chk("arst_pos", {16'b0, position}, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
